ptc_alarm_seq: RTL and testbench

- Wishbone master that programs the PTC timer so the temperature alarm's PWM output matches the current alarm level.
- The alarm-decision logic presents a 2-bit level. This block turns each level change into a fixed sequence of PTC register writes: stop, HRC, LRC, then enable.
- It sits between the alarm logic and the PTC slave port, and is the only master that ever drives the PTC.

---
 rtl/ptc_alarm_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_ptc_alarm_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptc_alarm_seq.sv
// rtl/ptc_alarm_seq.sv - Wishbone master sequencing PTC register writes for alarm levels
//
// Purpose: each accepted alarm-level change is turned into a fixed series of
// PTC register writes: CTRL<-STOP, then either CTRL<-OFF (level 0) or
// HRC<-period/2, LRC<-period, CTRL<-RUN (levels 1..3).
//
// Optional feature macro: PTC_SEQ_TIMEOUT_EN (bus timeout of TMO_CYC cycles,
// handled exactly like wbm_err_i). Without it the block waits forever.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   lvl_i, lvl_vld_i        requested level and its one-cycle strobe
//   busy_o                  a programming sequence is in progress
//   cur_lvl_o               last level successfully programmed
//   err_o                   sticky: last sequence aborted by bus error/timeout
//   wbm_*                   Wishbone master write port toward the PTC
module ptc_alarm_seq #(
    parameter logic [31:0] PTC_BASE = 32'h0000_0000,
    parameter logic [31:0] LRC_L1   = 32'd50000,
    parameter logic [31:0] LRC_L2   = 32'd25000,
    parameter logic [31:0] LRC_L3   = 32'd10000,
    parameter logic [15:0] TMO_CYC  = 16'd255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [1:0]  lvl_i,
    input  logic        lvl_vld_i,
    output logic        busy_o,
    output logic [1:0]  cur_lvl_o,
    output logic        err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [2:0] {
        IDLE, W_STOP, W_HRC, W_LRC, W_RUN, W_OFF, GAP
    } state_t;

    localparam logic [31:0] CTRL_STOP = 32'h0000_0080;
    localparam logic [31:0] CTRL_OFF  = 32'h0000_0000;
    localparam logic [31:0] CTRL_RUN  = 32'h0000_0009;

    state_t      state_q, state_d;
    state_t      nxt_q, nxt_d;          // write to issue when GAP ends
    logic        cyc_q, cyc_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        busy_q, busy_d;
    logic [1:0]  cur_q, cur_d;
    logic        err_q, err_d;
    logic [1:0]  tgt_q, tgt_d;          // level being programmed
    logic        pend_vld_q, pend_vld_d;
    logic [1:0]  pend_lvl_q, pend_lvl_d;
    logic        tmo_hit;

    function automatic logic [31:0] lrc_of(input logic [1:0] lvl);
        case (lvl)
            2'd1:    lrc_of = LRC_L1;
            2'd2:    lrc_of = LRC_L2;
            default: lrc_of = LRC_L3;
        endcase
    endfunction

    function automatic logic [31:0] wr_adr(input state_t s);
        case (s)
            W_HRC:   wr_adr = PTC_BASE + 32'h4;
            W_LRC:   wr_adr = PTC_BASE + 32'h8;
            default: wr_adr = PTC_BASE + 32'hC;
        endcase
    endfunction

    function automatic logic [31:0] wr_dat(input state_t s, input logic [1:0] lvl);
        case (s)
            W_STOP:  wr_dat = CTRL_STOP;
            W_HRC:   wr_dat = lrc_of(lvl) >> 1;
            W_LRC:   wr_dat = lrc_of(lvl);
            W_RUN:   wr_dat = CTRL_RUN;
            default: wr_dat = CTRL_OFF;
        endcase
    endfunction

`ifdef PTC_SEQ_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Counts cycles with stb high; stb always drops between writes, so
    // clearing while stb is low restarts the count for every write.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            tmo_cnt_q <= 16'd0;
        else if (!cyc_q)
            tmo_cnt_q <= 16'd0;
        else
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end

    // Fires on the edge that closes the TMO_CYC-th cycle of stb.
    assign tmo_hit = cyc_q && (tmo_cnt_q >= TMO_CYC - 16'd1);

    logic unused_sig;
    assign unused_sig = ^wbm_dat_i;
`else
    assign tmo_hit = 1'b0;

    logic unused_sig;
    assign unused_sig = ^{wbm_dat_i, TMO_CYC};
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            nxt_q      <= IDLE;
            cyc_q      <= 1'b0;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
            busy_q     <= 1'b0;
            cur_q      <= 2'd0;
            err_q      <= 1'b0;
            tgt_q      <= 2'd0;
            pend_vld_q <= 1'b0;
            pend_lvl_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            nxt_q      <= nxt_d;
            cyc_q      <= cyc_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            busy_q     <= busy_d;
            cur_q      <= cur_d;
            err_q      <= err_d;
            tgt_q      <= tgt_d;
            pend_vld_q <= pend_vld_d;
            pend_lvl_q <= pend_lvl_d;
        end
    end

    logic       bus_err;
    logic       bus_ack;
    logic       eff_vld;
    logic [1:0] eff_lvl;

    // Error wins over a simultaneous ack.
    assign bus_err = cyc_q && (wbm_err_i || tmo_hit);
    assign bus_ack = cyc_q && wbm_ack_i && !bus_err;
    // A strobe arriving on the completion edge is treated as pending.
    assign eff_vld = lvl_vld_i || pend_vld_q;
    assign eff_lvl = lvl_vld_i ? lvl_i : pend_lvl_q;

    always_comb begin
        state_d    = state_q;
        nxt_d      = nxt_q;
        cyc_d      = cyc_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        busy_d     = busy_q;
        cur_d      = cur_q;
        err_d      = err_q;
        tgt_d      = tgt_q;
        pend_vld_d = pend_vld_q;
        pend_lvl_d = pend_lvl_q;

        if (state_q != IDLE && lvl_vld_i) begin
            pend_vld_d = 1'b1;
            pend_lvl_d = lvl_i;
        end

        case (state_q)
            IDLE: begin
                if (lvl_vld_i && (lvl_i != cur_q || err_q)) begin
                    err_d   = 1'b0;
                    tgt_d   = lvl_i;
                    busy_d  = 1'b1;
                    state_d = W_STOP;
                    cyc_d   = 1'b1;
                    adr_d   = wr_adr(W_STOP);
                    dat_d   = wr_dat(W_STOP, lvl_i);
                end
            end

            GAP: begin
                state_d = nxt_q;
                cyc_d   = 1'b1;
                adr_d   = wr_adr(nxt_q);
                dat_d   = wr_dat(nxt_q, tgt_q);
            end

            W_STOP, W_HRC, W_LRC, W_RUN, W_OFF: begin
                if (bus_err) begin
                    cyc_d      = 1'b0;
                    err_d      = 1'b1;
                    busy_d     = 1'b0;
                    pend_vld_d = 1'b0;
                    state_d    = IDLE;
                end else if (bus_ack) begin
                    cyc_d   = 1'b0;
                    state_d = GAP;
                    case (state_q)
                        W_STOP:  nxt_d = (tgt_q == 2'd0) ? W_OFF : W_HRC;
                        W_HRC:   nxt_d = W_LRC;
                        W_LRC:   nxt_d = W_RUN;
                        default: begin
                            // Final write of the sequence.
                            cur_d      = tgt_q;
                            pend_vld_d = 1'b0;
                            if (eff_vld && eff_lvl != tgt_q) begin
                                tgt_d = eff_lvl;
                                nxt_d = W_STOP;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = IDLE;
                            end
                        end
                    endcase
                end
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy_o    = busy_q;
    assign cur_lvl_o = cur_q;
    assign err_o     = err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = cyc_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = {4{cyc_q}};

endmodule

// File: tb/tb_ptc_alarm_seq.sv
// tb/tb_ptc_alarm_seq.sv - self-checking bench for ptc_alarm_seq
module tb_ptc_alarm_seq;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  lvl = 2'd0;
    logic        vld = 1'b0;
    logic        busy;
    logic [1:0]  cur;
    logic        err;
    logic        cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        ack = 1'b0;
    logic        serr = 1'b0;

    int errors = 0;
    int checks = 0;

    // slave behaviour controls
    logic        no_ack   = 1'b0;
    logic        err_en   = 1'b0;
    logic [31:0] err_adr  = 32'd0;
    int          scnt     = 0;
    int          nlog     = 0;
    logic [31:0] log_adr [0:255];
    logic [31:0] log_dat [0:255];

    ptc_alarm_seq #(
        .PTC_BASE(BASE),
        .LRC_L1(32'd50000),
        .LRC_L2(32'd25000),
        .LRC_L3(32'd10000),
        .TMO_CYC(16'd8)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .lvl_i(lvl),
        .lvl_vld_i(vld),
        .busy_o(busy),
        .cur_lvl_o(cur),
        .err_o(err),
        .wbm_cyc_o(cyc),
        .wbm_stb_o(stb),
        .wbm_we_o(we),
        .wbm_adr_o(adr),
        .wbm_dat_o(dat),
        .wbm_sel_o(sel),
        .wbm_dat_i(32'd0),
        .wbm_ack_i(ack),
        .wbm_err_i(serr)
    );

    always #5 clk = ~clk;

    // Slave: answers in the cycle after stb is first seen, logs every answered write.
    always @(negedge clk) begin
        if (stb) begin
            scnt = scnt + 1;
            if (scnt == 2 && !no_ack) begin
                if (err_en && adr == err_adr) serr = 1'b1;
                else                           ack  = 1'b1;
                if (nlog < 256) begin
                    log_adr[nlog] = adr;
                    log_dat[nlog] = dat;
                end
                nlog = nlog + 1;
            end else begin
                ack  = 1'b0;
                serr = 1'b0;
            end
        end else begin
            scnt = 0;
            ack  = 1'b0;
            serr = 1'b0;
        end
    end

    // Presents one strobe; returns at the negedge just after the sampling edge.
    task automatic req(input logic [1:0] l);
        @(negedge clk);
        lvl = l;
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n = n + 1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, cur, err, cyc, stb, we, adr, dat, sel} !== 75'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b cur=%0d err=%b cyc=%b adr=%h dat=%h sel=%h, want all zero",
                     busy, cur, err, cyc, adr, dat, sel);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cyc !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b cyc=%b, want 0 0", busy, cyc);
        end
    endtask

    // Checks the writes logged from index b against expected address offsets/data.
    task automatic check_writes(input string nm, input int b, input int n,
                                input logic [31:0] eo [0:3], input logic [31:0] ed [0:3]);
        checks++;
        if (nlog - b !== n) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, want %0d", nm, nlog - b, n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (log_adr[b+i] !== BASE + eo[i] || log_dat[b+i] !== ed[i]) begin
                errors++;
                $display("FAIL %s_write%0d: got adr=%h dat=%0d, want adr=%h dat=%0d",
                         nm, i, log_adr[b+i], log_dat[b+i], BASE + eo[i], ed[i]);
            end
        end
    endtask

    task automatic test_level2;
        int b, n;
        logic [31:0] eo [0:3];
        logic [31:0] ed [0:3];
        eo = '{32'hC, 32'h4, 32'h8, 32'hC};
        ed = '{32'h80, 32'd12500, 32'd25000, 32'h09};
        b = nlog;
        req(2'd2);
        checks++;
        if (stb !== 1'b1 || we !== 1'b1 || sel !== 4'hF) begin
            errors++;
            $display("FAIL l2_first_stb: got stb=%b we=%b sel=%h, want 1 1 f", stb, we, sel);
        end
        wait_idle(n);
        checks++;
        if (n !== 11) begin
            errors++;
            $display("FAIL l2_busy_cycles: got %0d, want 11", n);
        end
        checks++;
        if (cur !== 2'd2 || err !== 1'b0 || stb !== 1'b0) begin
            errors++;
            $display("FAIL l2_final: got cur=%0d err=%b stb=%b, want 2 0 0", cur, err, stb);
        end
        check_writes("l2", b, 4, eo, ed);
    endtask

    task automatic test_level0;
        int b, n;
        logic [31:0] eo [0:3];
        logic [31:0] ed [0:3];
        eo = '{32'hC, 32'hC, 32'h0, 32'h0};
        ed = '{32'h80, 32'h00, 32'h0, 32'h0};
        b = nlog;
        req(2'd0);
        wait_idle(n);
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL l0_busy_cycles: got %0d, want 5", n);
        end
        checks++;
        if (cur !== 2'd0) begin
            errors++;
            $display("FAIL l0_cur: got %0d, want 0", cur);
        end
        check_writes("l0", b, 2, eo, ed);
    endtask

    task automatic test_pending;
        int b, n;
        logic [31:0] eo [0:3];
        logic [31:0] ed [0:3];
        eo = '{32'hC, 32'h4, 32'h8, 32'hC};
        ed = '{32'h80, 32'd12500, 32'd25000, 32'h09};
        b = nlog;
        req(2'd1);
        @(negedge clk);
        lvl = 2'd3;
        vld = 1'b1;
        @(negedge clk);
        lvl = 2'd2;
        @(negedge clk);
        vld = 1'b0;
        wait_idle(n);
        checks++;
        if (n + 3 !== 23) begin
            errors++;
            $display("FAIL pend_busy_cycles: got %0d, want 23 continuous", n + 3);
        end
        checks++;
        if (cur !== 2'd2) begin
            errors++;
            $display("FAIL pend_cur: got %0d, want 2", cur);
        end
        checks++;
        if (log_dat[b+1] !== 32'd25000 || log_dat[b+2] !== 32'd50000) begin
            errors++;
            $display("FAIL pend_l1_data: got hrc=%0d lrc=%0d, want 25000 50000",
                     log_dat[b+1], log_dat[b+2]);
        end
        check_writes("pend_l2", b + 4, 4, eo, ed);
    endtask

    task automatic test_err;
        int n;
        err_en  = 1'b1;
        err_adr = BASE + 32'h4;
        req(2'd3);
        wait_idle(n);
        checks++;
        if (n !== 5 || err !== 1'b1 || busy !== 1'b0 || stb !== 1'b0) begin
            errors++;
            $display("FAIL err_abort: got cycles=%0d err=%b busy=%b stb=%b, want 5 1 0 0",
                     n, err, busy, stb);
        end
        checks++;
        if (cur !== 2'd2) begin
            errors++;
            $display("FAIL err_cur: got %0d, want 2", cur);
        end
        err_en = 1'b0;
        req(2'd2);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL err_rereq_accept: got busy=%b err=%b, want 1 0", busy, err);
        end
        wait_idle(n);
        checks++;
        if (n !== 11 || cur !== 2'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL err_rereq_done: got cycles=%0d cur=%0d err=%b, want 11 2 0", n, cur, err);
        end
        req(2'd2);
        checks++;
        if (busy !== 1'b0 || stb !== 1'b0) begin
            errors++;
            $display("FAIL same_lvl_ignored: got busy=%b stb=%b, want 0 0", busy, stb);
        end
    endtask

    task automatic test_hang;
        no_ack = 1'b1;
        req(2'd1);
`ifdef PTC_SEQ_TIMEOUT_EN
        repeat (7) @(negedge clk);
        checks++;
        if (stb !== 1'b1) begin
            errors++;
            $display("FAIL tmo_before: got stb=%b, want 1", stb);
        end
        @(negedge clk);
        checks++;
        if (stb !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_fire: got stb=%b err=%b busy=%b, want 0 1 0", stb, err, busy);
        end
`else
        repeat (1000) @(negedge clk);
        checks++;
        if (stb !== 1'b1 || busy !== 1'b1 || adr !== BASE + 32'hC) begin
            errors++;
            $display("FAIL no_tmo_wait: got stb=%b busy=%b adr=%h, want 1 1 %h",
                     stb, busy, adr, BASE + 32'hC);
        end
`endif
        no_ack = 1'b0;
        test_reset();
    endtask

    task automatic test_reset_mid;
        int b, n;
        logic [31:0] eo [0:3];
        logic [31:0] ed [0:3];
        eo = '{32'hC, 32'h4, 32'h8, 32'hC};
        ed = '{32'h80, 32'd5000, 32'd10000, 32'h09};
        req(2'd3);
        repeat (6) @(negedge clk);
        checks++;
        if (stb !== 1'b1 || adr !== BASE + 32'h8) begin
            errors++;
            $display("FAIL mid_in_lrc: got stb=%b adr=%h, want 1 %h", stb, adr, BASE + 32'h8);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, cur, err, cyc, stb, we, adr, dat, sel} !== 75'd0) begin
            errors++;
            $display("FAIL mid_async_reset: got busy=%b cur=%0d err=%b cyc=%b stb=%b adr=%h, want all zero",
                     busy, cur, err, cyc, stb, adr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        b = nlog;
        req(2'd3);
        wait_idle(n);
        checks++;
        if (n !== 11 || cur !== 2'd3 || err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_l3: got cycles=%0d cur=%0d err=%b, want 11 3 0", n, cur, err);
        end
        check_writes("l3", b, 4, eo, ed);
    endtask

    initial begin
        test_reset();
        test_level2();
        test_level0();
        test_pending();
        test_err();
        test_hang();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
